clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
Programmable, run-time reconfigurable clock-enable/divided-clock generator. It is the parametrised successor to the fixed-compare toggle divider in the heart-rate datapath. It produces a 50 % duty divided clock level and a single-cycle rising-edge tick from the 100 MHz system clock. The half-period is loadable at run time and is applied glitch-free at the next toggle boundary. It feeds the sampling/display timing blocks, which consume `tick` as a clock enable.

Parameters:
WIDTH, 26, width of the half-period counter and divisor registers
DEFAULT_HALF, 10001, half-period in clk cycles after reset (output period = 2*DEFAULT_HALF)
INIT_LEVEL, 1, reset value of clk_out

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
en  input  1  count enable; 0 freezes divider state
div_val  input  WIDTH  new half-period in clk cycles; 0 is treated as 1
div_load  input  1  one-cycle strobe; captures div_val into the pending register
clk_out  output  1  divided clock level, registered
tick  output  1  one-cycle pulse coincident with each 0->1 transition of clk_out
load_pending  output  1  high while a loaded divisor awaits its boundary

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: count=0, div_active=DEFAULT_HALF, div_pend=0, load_pending=0, clk_out=INIT_LEVEL, tick=0.
- Effective half-period: H = (div_active==0) ? 1 : div_active.
- Cycle with en=1 and count==H-1 (boundary):
  - count<=0, clk_out<=~clk_out.
  - tick<=1 only if clk_out is currently 0, so tick and clk_out rise in the same cycle.
  - If load_pending=1: div_active<=div_pend, load_pending<=0.
- Cycle with en=1, not a boundary: count<=count+1, tick<=0.
- Cycle with en=0: count, clk_out and div_active hold; tick<=0. Pending load still accepted.
- Output period is 2*H cycles with exact 50 % duty. With H=1, clk_out toggles every enabled cycle and tick pulses every second cycle.
- div_load=1: div_pend<=div_val, load_pending<=1. A later load overwrites an earlier unapplied one (last-wins).
- div_load on a boundary cycle:
  - The boundary applies the previously pending value, if any.
  - The new value becomes pending and is applied at the following boundary.
  - load_pending stays 1.
- Divisor changes occur only when count returns to 0. No runt or shortened half-periods are ever generated.
- Counter width: count never exceeds H-1 and never wraps.
- rst asserted mid-operation: all state returns to reset values on the next edge, and any pending load is discarded.
- Latency: clk_out/tick are registered. The first toggle after reset occurs at the H-th enabled rising edge.

Optional Feature:
Macro CLK_DIV_SYNC_EN.
- Defined: adds input port sync_in (1 bit). When sync_in=1 (and rst=0), the next edge forces:
  - count<=0, clk_out<=1, tick<=1.
  - Applies a pending divisor immediately (load_pending<=0).
  - sync_in takes priority over en and over a boundary. Used to phase-align the divider to an external beat event.
- Not defined: no sync_in port; behaviour is exactly as above.

Test Plan:
- Reset, H=DEFAULT_HALF overridden to 3 via parameter, en=1 -> clk_out toggles every 3 cycles (period 6); tick high once every 6 cycles, aligned with each clk_out rise; clk_out starts at 1.
- Load div_val=5 mid-half-period -> load_pending=1; current half-period still completes with 3 cycles; subsequent half-periods are 5 cycles; load_pending clears on that boundary.
- div_load coincident with boundary while value 4 is pending, new value 7 -> 4 applied at this boundary; 7 applied at the next; no half-period of other length.
- div_val=0 and div_val=1 -> both give clk_out toggling every cycle and tick every 2 cycles.
- en deasserted for 10 cycles mid-count -> clk_out, count frozen, tick=0 throughout; count resumes from held value.
- rst pulsed while load pending (and, with CLK_DIV_SYNC_EN, a sync_in pulse mid-half-period) -> all state returns to reset values and the pending load is lost; with the macro, sync_in gives clk_out=1 and tick=1 on the next edge, count restarts at 0.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable clock divider: 50% duty clk_out plus a rising-edge tick.
// Ports: clk, rst (sync, active-high), en, div_val, div_load -> clk_out,
//   tick, load_pending. Optional macro CLK_DIV_SYNC_EN adds sync_in.
module clk_div_prog #(
    parameter int WIDTH        = 26,
    parameter int DEFAULT_HALF = 10001,
    parameter bit INIT_LEVEL   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync_in,
`endif
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             load_pending
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div_active;
    logic [WIDTH-1:0] div_pend;
    logic [WIDTH-1:0] half;
    logic             boundary;
    logic             sync;

`ifdef CLK_DIV_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    // A zero divisor behaves as a half-period of one cycle.
    assign half     = (div_active == '0) ? WIDTH'(1) : div_active;
    assign boundary = en && (count == half - WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            div_active   <= WIDTH'(DEFAULT_HALF);
            div_pend     <= '0;
            load_pending <= 1'b0;
            clk_out      <= INIT_LEVEL;
            tick         <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (sync) begin
                count   <= '0;
                clk_out <= 1'b1;
                tick    <= 1'b1;
                if (load_pending) begin
                    div_active   <= div_pend;
                    load_pending <= 1'b0;
                end
            end else if (boundary) begin
                count   <= '0;
                clk_out <= ~clk_out;
                // Tick only on the 0->1 transition of clk_out.
                tick    <= ~clk_out;
                if (load_pending) begin
                    div_active   <= div_pend;
                    load_pending <= 1'b0;
                end
            end else if (en) begin
                count <= count + WIDTH'(1);
            end
            // A load in the same cycle as an apply stays pending for
            // the following boundary (last assignment wins).
            if (div_load) begin
                div_pend     <= div_val;
                load_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed table, corner sequences
// and randomized stimulus against a half-period reference model.
module tb_clk_div_prog;

    localparam int W  = 8;
    localparam int DH = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] div_val;
    logic         div_load;
    logic         clk_out;
    logic         tick;
    logic         load_pending;
`ifdef CLK_DIV_SYNC_EN
    logic         sync_in = 1'b0;
`endif

    clk_div_prog #(.WIDTH(W), .DEFAULT_HALF(DH), .INIT_LEVEL(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
`ifdef CLK_DIV_SYNC_EN
        .sync_in      (sync_in),
`endif
        .div_val      (div_val),
        .div_load     (div_load),
        .clk_out      (clk_out),
        .tick         (tick),
        .load_pending (load_pending)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: a half-period lasts eff(h) enabled cycles; new
    // divisors wait in a one-deep last-wins queue until a half ends.
    bit m_level;
    bit m_tick;
    int m_elapsed;
    int m_h;
    int m_q[$];

    function automatic int eff(int h);
        return (h == 0) ? 1 : h;
    endfunction

    function automatic bit m_next_is_boundary();
        return (m_elapsed + 1) == eff(m_h);
    endfunction

    task automatic model_edge(bit r, bit e, int v, bit ld);
        if (r) begin
            m_level   = 1'b1;
            m_tick    = 1'b0;
            m_elapsed = 0;
            m_h       = DH;
            m_q.delete();
        end else begin
            m_tick = 1'b0;
            if (e) begin
                m_elapsed++;
                if (m_elapsed == eff(m_h)) begin
                    m_level   = ~m_level;
                    m_tick    = m_level;
                    m_elapsed = 0;
                    if (m_q.size() != 0) m_h = m_q.pop_front();
                end
            end
            if (ld) begin
                m_q.delete();
                m_q.push_back(v);
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // One clock edge; DUT outputs compared against the model after it.
    task automatic step(bit r, bit e, int v, bit ld);
        rst      = r;
        en       = e;
        div_val  = W'(v);
        div_load = ld;
        @(posedge clk);
        #1;
        model_edge(r, e, v, ld);
        chk("clk_out", int'(clk_out), int'(m_level));
        chk("tick", int'(tick), int'(m_tick));
        chk("load_pending", int'(load_pending), int'(m_q.size() != 0));
    endtask

    // Enabled cycles until clk_out next changes, bounded.
    task automatic wait_toggle(output int n);
        bit prev;
        prev = clk_out;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, 0, 1'b0);
            n++;
            if (clk_out != prev) return;
        end
        n = -1;
    endtask

    typedef struct {
        bit r;
        bit e;
        int v;
        bit ld;
        bit x_clk;
        bit x_tick;
        bit x_pend;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; div_val = '0; div_load = 1'b0;

        tbl = '{
            '{1,0,0,0, 1,0,0},
            '{0,1,0,0, 1,0,0},
            '{0,1,0,0, 1,0,0},
            '{0,1,0,0, 0,0,0},
            '{0,1,0,0, 0,0,0},
            '{0,1,0,0, 0,0,0},
            '{0,1,0,0, 1,1,0},
            '{0,1,5,1, 1,0,1},
            '{0,1,0,0, 1,0,1},
            '{0,1,0,0, 0,0,0},
            '{0,1,0,0, 0,0,0},
            '{0,1,0,0, 0,0,0},
            '{0,1,0,0, 0,0,0},
            '{0,1,0,0, 0,0,0},
            '{0,1,0,0, 1,1,0},
            '{0,0,0,0, 1,0,0},
            '{0,1,0,0, 1,0,0},
            '{0,1,0,1, 1,0,1},
            '{0,1,0,0, 1,0,1},
            '{0,1,0,0, 1,0,1},
            '{0,1,0,0, 0,0,0},
            '{0,1,0,0, 1,1,0},
            '{0,1,0,0, 0,0,0},
            '{0,1,0,0, 1,1,0}
        };
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].ld);
            chk($sformatf("tbl%0d_clk", i), int'(clk_out), int'(tbl[i].x_clk));
            chk($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].x_tick));
            chk($sformatf("tbl%0d_pend", i), int'(load_pending),
                int'(tbl[i].x_pend));
        end

        // Load coincident with a boundary while 4 is pending.
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 4, 1'b1);
        for (int i = 0; i < 20 && !m_next_is_boundary(); i++)
            step(1'b0, 1'b1, 0, 1'b0);
        step(1'b0, 1'b1, 7, 1'b1);
        chk("bnd_load_pending", int'(load_pending), 1);
        wait_toggle(n);
        chk("half_after_4", n, 4);
        chk("pend_cleared", int'(load_pending), 0);
        wait_toggle(n);
        chk("half_after_7a", n, 7);
        wait_toggle(n);
        chk("half_after_7b", n, 7);

        // div_val=1: toggle every cycle.
        step(1'b0, 1'b1, 1, 1'b1);
        wait_toggle(n);
        wait_toggle(n);
        chk("half_one", n, 1);

        // Freeze for 10 cycles mid-count.
        step(1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 0, 1'b0);
            chk("frz_clk", int'(clk_out), 1);
            chk("frz_tick", int'(tick), 0);
        end
        wait_toggle(n);
        chk("resume_half", n, 2);

        // Reset discards a pending load.
        step(1'b0, 1'b1, 9, 1'b1);
        step(1'b1, 1'b1, 0, 1'b0);
        chk("rst_pend", int'(load_pending), 0);
        chk("rst_clk", int'(clk_out), 1);
        wait_toggle(n);
        chk("rst_first_half", n, DH);
        wait_toggle(n);
        chk("rst_second_half", n, DH);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 8,
                 int'($urandom_range(0, 6)),
                 $urandom_range(0, 19) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
